// File: rtl/insn_fetch_queue.sv
// Fetch-to-decode instruction queue: holds insn, PC and branch-prediction
// metadata and presents the oldest entry through a valid/ready handshake.
module insn_fetch_queue #(
  parameter int LG_DEPTH  = 3,
  parameter int M_WIDTH   = 32,
  parameter int LG_PHT_SZ = 16,
  parameter int AF_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_insn,
  input  logic [M_WIDTH-1:0]   in_pc,
  input  logic                 in_pred,
  input  logic [LG_PHT_SZ-1:0] in_pht_idx,
  input  logic [M_WIDTH-1:0]   in_pred_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_insn,
  output logic [M_WIDTH-1:0]   out_pc,
  output logic                 out_pred,
  output logic [LG_PHT_SZ-1:0] out_pht_idx,
  output logic [M_WIDTH-1:0]   out_pred_target,
  output logic [LG_DEPTH:0]    count,
  output logic                 almost_full,
  output logic [31:0]          drop_cnt
);

  localparam int DEPTH = 1 << LG_DEPTH;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high and flush is low; ready never depends on the opposite side.

  logic [LG_DEPTH:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]       drop_q, drop_d;
  logic              full, empty, push, pop;

  logic [31:0]          insn_mem [DEPTH];
  logic [M_WIDTH-1:0]   pc_mem   [DEPTH];
  logic                 pred_mem [DEPTH];
  logic [LG_PHT_SZ-1:0] pht_mem  [DEPTH];
  logic [M_WIDTH-1:0]   tgt_mem  [DEPTH];

  assign empty = (head_q == tail_q);
  assign full  = (head_q[LG_DEPTH] != tail_q[LG_DEPTH]) &&
                 (head_q[LG_DEPTH-1:0] == tail_q[LG_DEPTH-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    drop_d = drop_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push) tail_d = tail_q + (LG_DEPTH+1)'(1);
      if (pop)  head_d = head_q + (LG_DEPTH+1)'(1);
    end
    // Back-pressure counter saturates rather than wrapping and survives flush.
    if (in_valid && !in_ready && !flush && (drop_q != 32'hFFFF_FFFF))
      drop_d = drop_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      drop_q <= drop_d;
    end
  end

  // Storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem[tail_q[LG_DEPTH-1:0]] <= in_insn;
      pc_mem[tail_q[LG_DEPTH-1:0]]   <= in_pc;
      pred_mem[tail_q[LG_DEPTH-1:0]] <= in_pred;
      pht_mem[tail_q[LG_DEPTH-1:0]]  <= in_pht_idx;
      tgt_mem[tail_q[LG_DEPTH-1:0]]  <= in_pred_target;
    end
  end

  assign out_insn        = insn_mem[head_q[LG_DEPTH-1:0]];
  assign out_pc          = pc_mem[head_q[LG_DEPTH-1:0]];
  assign out_pred        = pred_mem[head_q[LG_DEPTH-1:0]];
  assign out_pht_idx     = pht_mem[head_q[LG_DEPTH-1:0]];
  assign out_pred_target = tgt_mem[head_q[LG_DEPTH-1:0]];

  assign count       = tail_q - head_q;
  assign almost_full = (32'(count) >= 32'(AF_THRESH));
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Bench for insn_fetch_queue: vector table for the fill sequence, a
// negedge scoreboard for ordering/occupancy, and directed corner sequences.
module tb_insn_fetch_queue;

  localparam int EW = 32 + 32 + 1 + 16 + 32;

  logic        clk, reset, flush;
  logic        in_valid, in_ready, in_pred, out_valid, out_ready, out_pred;
  logic [31:0] in_insn, in_pc, in_pred_target;
  logic [31:0] out_insn, out_pc, out_pred_target, drop_cnt;
  logic [15:0] in_pht_idx, out_pht_idx;
  logic [3:0]  count;
  logic        almost_full;

  insn_fetch_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
    .in_pred(in_pred), .in_pht_idx(in_pht_idx), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
    .out_pred(out_pred), .out_pht_idx(out_pht_idx), .out_pred_target(out_pred_target),
    .count(count), .almost_full(almost_full), .drop_cnt(drop_cnt)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;
  logic [31:0]   drop_m = 0;
  logic [EW-1:0] exp_q[$];
  int sz;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // scoreboard: model occupancy from the expected queue, check every cycle
  always @(negedge clk) begin
    if (reset) begin
      sz = exp_q.size();
      chk("mon_count", 128'(count), 128'(sz));
      chk("mon_out_valid", 128'(out_valid), 128'(sz != 0));
      chk("mon_in_ready", 128'(in_ready), 128'(sz != 8));
      chk("mon_almost_full", 128'(almost_full), 128'(sz >= 6));
      chk("mon_drop_cnt", 128'(drop_cnt), 128'(drop_m));
      if (flush) begin
        exp_q.delete();
      end else begin
        if (sz != 0 && out_ready) begin
          chk("pop_entry", 128'({out_insn, out_pc, out_pred, out_pht_idx, out_pred_target}),
              128'(exp_q[0]));
          void'(exp_q.pop_front());
          pop_cnt++;
        end
        if (in_valid && sz != 8)
          exp_q.push_back({in_insn, in_pc, in_pred, in_pht_idx, in_pred_target});
        if (in_valid && sz == 8 && drop_m != 32'hFFFF_FFFF)
          drop_m = drop_m + 1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc);
    in_valid       = v;
    in_insn        = insn;
    in_pc          = pc;
    in_pred        = 1'($urandom_range(0, 1));
    in_pht_idx     = 16'($urandom_range(0, 65535));
    in_pred_target = $urandom;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, $urandom, base + 32'(i * 4));
      tick();
    end
    idle();
  endtask

  task automatic drain();
    int k;
    idle();
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout act=%0d exp=0", exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic in_valid;
    logic out_ready;
    int   exp_count;
    logic exp_af;
    logic exp_in_ready;
    int   exp_drop;
  } vec_t;

  vec_t vecs[9];
  int   pushed, pops0, cyc;
  logic acc;
  logic [31:0] drop_save;

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, i + 1, (i + 1) >= 6, (i + 1) != 8, 0};
    vecs[8] = '{1'b1, 1'b1, 7, 1'b1, 1'b1, 1};

    // reset / empty
    reset = 1'b0;
    idle();
    #12;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_almost_full", 128'(almost_full), 128'(0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    reset = 1'b1;
    tick();

    // first push appears the following cycle, no bypass
    drive(1'b1, 32'h0010_0093, 32'h0000_1000);
    #2;
    chk("nobypass_out_valid", 128'(out_valid), 128'(0));
    tick();
    idle();
    chk("first_out_valid", 128'(out_valid), 128'(1));
    chk("first_out_insn", 128'(out_insn), 128'(32'h0010_0093));
    chk("first_out_pc", 128'(out_pc), 128'(32'h0000_1000));
    drain();

    // fill table
    for (int i = 0; i < 9; i++) begin
      out_ready = vecs[i].out_ready;
      drive(vecs[i].in_valid, $urandom, 32'(i * 4));
      tick();
      chk("fill_count", 128'(count), 128'(vecs[i].exp_count));
      chk("fill_af", 128'(almost_full), 128'(vecs[i].exp_af));
      chk("fill_in_ready", 128'(in_ready), 128'(vecs[i].exp_in_ready));
      chk("fill_drop", 128'(drop_cnt), 128'(vecs[i].exp_drop));
    end
    drain();

    // order and wrap with random handshakes
    pushed = 0;
    pops0  = pop_cnt;
    cyc    = 0;
    while ((pushed < 20 || exp_q.size() != 0) && cyc < 400) begin
      drive((pushed < 20) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, 32'h2000 + 32'(pushed * 4));
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      tick();
      if (acc) pushed++;
      cyc++;
    end
    idle();
    chk("stream_pops", 128'(pop_cnt - pops0), 128'(20));

    // steady state at count 3
    push_n(3, 32'h3000);
    pops0 = pop_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, 32'h3100 + 32'(i * 4));
      tick();
      chk("steady_count", 128'(count), 128'(3));
    end
    idle();
    chk("steady_pops", 128'(pop_cnt - pops0), 128'(10));
    drain();

    // flush priority at count 5
    push_n(5, 32'h4000);
    drop_save = drop_m;
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 32'h4444);
    tick();
    idle();
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_drop", 128'(drop_cnt), 128'(drop_save));
    push_n(2, 32'h4800);
    drain();

    // async reset mid-stream at count 4
    push_n(4, 32'h5000);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", 128'(count), 128'(0));
    chk("async_out_valid", 128'(out_valid), 128'(0));
    chk("async_drop", 128'(drop_cnt), 128'(0));
    exp_q.delete();
    drop_m = 0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    push_n(3, 32'h6000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/insn_fetch_queue.md
# insn_fetch_queue

Decoupling FIFO between instruction fetch and `decode_riscv`. It buffers fetched instruction words together with their PC, branch prediction bit, PHT index and predicted target. It presents the oldest entry to the decoder through a valid/ready handshake. The whole queue is discarded on a pipeline flush, which happens on a mispredict, an exception or a restart.

## Interface
- `LG_DEPTH`, default 3: log2 of entry count (8 entries).
- `M_WIDTH`, default 32: PC / target width.
- `LG_PHT_SZ`, default 16: PHT index width.
- `AF_THRESH`, default 6: occupancy at or above which `almost_full` asserts.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all entries this cycle.
- `in_valid`  in  1  fetch presents an entry.
- `in_ready`  out  1  queue accepts the entry.
- `in_insn`  in  32  instruction word.
- `in_pc`  in  M_WIDTH  instruction PC.
- `in_pred`  in  1  predicted-taken bit.
- `in_pht_idx`  in  LG_PHT_SZ  PHT index.
- `in_pred_target`  in  M_WIDTH  predicted target.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  decoder consumes head.
- `out_insn`, `out_pc`, `out_pred`, `out_pht_idx`, `out_pred_target`  out  (widths as inputs)  head entry fields.
- `count`  out  LG_DEPTH+1  current occupancy, 0..2^LG_DEPTH.
- `almost_full`  out  1  `count >= AF_THRESH`.
- `drop_cnt`  out  32  cycles in which `in_valid & !in_ready & !flush`.

## Operation
- Storage: 2^LG_DEPTH entries. Pointers `head` and `tail` are each LG_DEPTH+1 bits.
  - The pointer MSB is the wrap bit.
  - Empty when `head == tail`.
  - Full when the low bits are equal and the MSBs differ.
  - `count = tail - head`, modulo 2^(LG_DEPTH+1).
- Push fires when `in_valid & in_ready & !flush`. It writes `mem[tail]` and increments `tail`.
- Pop fires when `out_valid & out_ready & !flush`. It increments `head`.
- `in_ready = !full`. It is a function of registered state only and never depends on `out_ready`. When the queue is full, a simultaneous pop does not enable a push in the same cycle.
- `out_valid = !empty`. The out fields are `mem[head]` read combinationally.
- When `out_valid = 0`, the out fields are don't-care. The bench must not check them.
- A push and a pop in the same non-full, non-empty cycle leave `count` unchanged.
- Pushing into an empty queue:
  - does not bypass to the output;
  - the entry appears on the output the following cycle.
- `flush`:
  - sets `head` and `tail` to 0 at the next edge;
  - the push and pop of that cycle are both suppressed;
  - `mem` contents are not cleared;
  - `flush` has priority over every other event.
- `drop_cnt`:
  - saturating increment at 0xFFFF_FFFF;
  - counts back-pressure cycles;
  - is not cleared by `flush`.
- Entry fields are stored bit-exact. No decode or filtering is done here; the all-zero word is queued normally.

## Timing
- Reset values while `reset = 0`, applied asynchronously:
  - `head = tail = 0`;
  - `out_valid = 0`, `in_ready = 1`, `count = 0`, `almost_full = 0`, `drop_cnt = 0`.
  - `mem` is not reset.
- Latency: an entry pushed at edge N is visible on the output after edge N, i.e. in cycle N+1. Minimum push-to-pop latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained while 0 < count < depth.
- Reset asserted mid-operation: the queue empties immediately. Any in-flight handshake is void.
- Pointer wrap: after 2^LG_DEPTH pushes, the low `tail` bits return to 0 and its MSB toggles. Full and empty remain correct across any number of wraps.
- All outputs are stable within a cycle. There are no combinational paths from `in_*` to `out_*`, or from `out_ready` to `in_ready`.

## Test plan
- **Reset/empty:** hold `reset = 0`, then release. Expect `out_valid = 0`, `in_ready = 1`, `count = 0`. Push `in_insn = 0x00100093`, `pc = 0x1000`. `out_valid` rises the next cycle carrying `0x00100093` / `0x1000`.
- **Fill:** with `out_ready = 0`, push 8 entries at PCs 0x0, 0x4 … 0x1C.
  - `count` steps 1..8; `almost_full` asserts at count 6.
  - `in_ready = 0` at count 8.
  - A ninth push with `out_ready = 1` is rejected, `drop_cnt` becomes 1, and `count` goes to 7.
- **Order and wrap:** stream 20 entries with `in_valid` and `out_ready` randomly toggled. The popped PC sequence exactly matches the push order, and all prediction fields (`pred`, `pht_idx`, `pred_target`) match per entry.
- **Steady state:** `in_valid = out_ready = 1` for 10 cycles starting at count 3. `count` stays at 3 and one entry is consumed per cycle.
- **Flush priority:** at count 5, assert `flush` together with `in_valid` and `out_ready`. Next cycle `count = 0`, `out_valid = 0`, and neither the pushed entry nor the popped entry takes effect. `drop_cnt` is unchanged.
- **Async reset mid-stream:** drop `reset` between clock edges with count 4. `count` and `out_valid` go to 0 without waiting for `clk`, and `drop_cnt` goes to 0.
